// File: rtl/spart_baud_ctrl_if.sv
// Processor-side bus of the SPART: chip select, direction, register address and data.
interface spart_baud_ctrl_if;
   logic       iocs;
   logic       iorw;
   logic [1:0] ioaddr;
   logic [7:0] bus_wdata;
   logic [7:0] bus_rdata;

   modport master (output iocs, iorw, ioaddr, bus_wdata, input bus_rdata);
   modport slave  (input iocs, iorw, ioaddr, bus_wdata, output bus_rdata);
endinterface

// File: rtl/spart_baud_ctrl.sv
// SPART bus controller: register decode, programmable baud divisor, 16x/1x enables,
// and the rx_ack / tx_load handshakes toward uart_rx / uart_tx.
module spart_baud_ctrl #(
   parameter logic [15:0] DEFAULT_DIV = 16'd162
) (
   input  logic               clk,
   input  logic               rst,
   spart_baud_ctrl_if.slave   bus,
   input  logic [7:0]         rx_buffer,
   input  logic               rda,
   input  logic               tbr,
   output logic               rx_en,
   output logic               tx_en,
   output logic               rx_ack,
   output logic               tx_load,
   output logic [7:0]         tx_data
);

   logic        cs_p1;
   logic [2:0]  acc_p1;
   logic [2:0]  acc_p0;
   logic        new_acc;
   logic        wr_acc;
   logic        rd_acc;
   logic [15:0] div_act;
   logic [7:0]  div_lo_s;
   logic [15:0] cnt;
   logic [3:0]  phase;
   logic        ovr;

   assign acc_p0  = {bus.iorw, bus.ioaddr};
   // Side effects fire only on the first cycle of an access, however long iocs is held.
   assign new_acc = bus.iocs && (!cs_p1 || (acc_p1 != acc_p0));
   assign wr_acc  = new_acc && !bus.iorw;
   assign rd_acc  = new_acc && bus.iorw;

   assign rx_en = (cnt == 16'd0);
   assign tx_en = rx_en && (phase == 4'd15);

   always_comb begin
      bus.bus_rdata = 8'h00;
      if (bus.iocs && bus.iorw) begin
         case (bus.ioaddr)
            2'b00:   bus.bus_rdata = rx_buffer;
            2'b01:   bus.bus_rdata = {5'b0, ovr, tbr, rda};
            2'b10:   bus.bus_rdata = div_act[7:0];
            default: bus.bus_rdata = div_act[15:8];
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cs_p1    <= 1'b0;
         acc_p1   <= 3'b000;
         div_act  <= DEFAULT_DIV;
         div_lo_s <= 8'h00;
         cnt      <= DEFAULT_DIV;
         phase    <= 4'd0;
         ovr      <= 1'b0;
         tx_data  <= 8'h00;
         rx_ack   <= 1'b0;
         tx_load  <= 1'b0;
      end else begin
         cs_p1   <= bus.iocs;
         acc_p1  <= acc_p0;
         rx_ack  <= rd_acc && (bus.ioaddr == 2'b00);
         tx_load <= wr_acc && (bus.ioaddr == 2'b00) && tbr;

         if (wr_acc && (bus.ioaddr == 2'b00) && tbr)
            tx_data <= bus.bus_wdata;

         // A dropped write setting ovr beats a status-read clear on the same edge.
         if (wr_acc && (bus.ioaddr == 2'b00) && !tbr)
            ovr <= 1'b1;
         else if (rd_acc && (bus.ioaddr == 2'b01))
            ovr <= 1'b0;

         if (wr_acc && (bus.ioaddr == 2'b10))
            div_lo_s <= bus.bus_wdata;

         // A divisor commit restarts the baud timing and overrides the terminal-count reload.
         if (wr_acc && (bus.ioaddr == 2'b11)) begin
            div_act <= {bus.bus_wdata, div_lo_s};
            cnt     <= {bus.bus_wdata, div_lo_s};
            phase   <= 4'd0;
         end else if (rx_en) begin
            cnt   <= div_act;
            phase <= phase + 4'd1;
         end else begin
            cnt <= cnt - 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_spart_baud_ctrl.sv
// Directed bench for spart_baud_ctrl: read-mux table plus baud, handshake and reset sequences.
module tb_spart_baud_ctrl;
   logic       clk;
   logic       rst;
   logic [7:0] rx_buffer;
   logic       rda;
   logic       tbr;
   logic       rx_en;
   logic       tx_en;
   logic       rx_ack;
   logic       tx_load;
   logic [7:0] tx_data;

   int n_chk  = 0;
   int n_pass = 0;

   spart_baud_ctrl_if bus_if ();

   spart_baud_ctrl #(.DEFAULT_DIV(16'd162)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus_if.slave),
      .rx_buffer (rx_buffer),
      .rda       (rda),
      .tbr       (tbr),
      .rx_en     (rx_en),
      .tx_en     (tx_en),
      .rx_ack    (rx_ack),
      .tx_load   (tx_load),
      .tx_data   (tx_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic       cs;
      logic       rw;
      logic [1:0] addr;
      logic [7:0] rxb;
      logic       rda;
      logic       tbr;
      logic [7:0] exp;
   } rvec_t;

   rvec_t tbl [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp)
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      else
         n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic cs, input logic rw, input logic [1:0] a, input logic [7:0] wd);
      bus_if.iocs      = cs;
      bus_if.iorw      = rw;
      bus_if.ioaddr    = a;
      bus_if.bus_wdata = wd;
   endtask

   // Index 0 is the current sample; rx_en expected at index 'first' and every 'per' after.
   task automatic run_check(input string nm, input int ncyc, input int per, input int first);
      int  erx = 0;
      int  etx = 0;
      bit  e_rx;
      bit  e_tx;
      for (int i = 1; i <= ncyc; i++) begin
         tick();
         e_rx = (i >= first) && (((i - first) % per) == 0);
         e_tx = e_rx && ((((i - first) / per) % 16) == 15);
         if (rx_en !== e_rx) erx++;
         if (tx_en !== e_tx) etx++;
      end
      check({nm, "_rx_en_errs"}, 32'(erx), 32'd0);
      check({nm, "_tx_en_errs"}, 32'(etx), 32'd0);
   endtask

   initial begin
      int bad;
      int acks;
      int ackpos;
      int w;

      tbl[0] = '{cs:1'b0, rw:1'b1, addr:2'd0, rxb:8'h5A, rda:1'b1, tbr:1'b1, exp:8'h00};
      tbl[1] = '{cs:1'b1, rw:1'b1, addr:2'd0, rxb:8'h5A, rda:1'b1, tbr:1'b1, exp:8'h5A};
      tbl[2] = '{cs:1'b1, rw:1'b1, addr:2'd1, rxb:8'h00, rda:1'b1, tbr:1'b0, exp:8'h01};
      tbl[3] = '{cs:1'b1, rw:1'b1, addr:2'd1, rxb:8'h00, rda:1'b0, tbr:1'b1, exp:8'h02};
      tbl[4] = '{cs:1'b1, rw:1'b1, addr:2'd1, rxb:8'h00, rda:1'b1, tbr:1'b1, exp:8'h03};
      tbl[5] = '{cs:1'b1, rw:1'b1, addr:2'd2, rxb:8'h00, rda:1'b0, tbr:1'b1, exp:8'hA2};
      tbl[6] = '{cs:1'b1, rw:1'b1, addr:2'd3, rxb:8'h00, rda:1'b0, tbr:1'b1, exp:8'h00};
      tbl[7] = '{cs:1'b1, rw:1'b0, addr:2'd1, rxb:8'h33, rda:1'b1, tbr:1'b1, exp:8'h00};

      rst       = 1'b0;
      rx_buffer = 8'h00;
      rda       = 1'b0;
      tbr       = 1'b1;
      drive(1'b0, 1'b0, 2'd0, 8'h00);

      // Reset and default baud
      repeat (3) @(negedge clk);
      check("rst_rx_en",   32'(rx_en),   32'd0);
      check("rst_tx_en",   32'(tx_en),   32'd0);
      check("rst_rx_ack",  32'(rx_ack),  32'd0);
      check("rst_tx_load", 32'(tx_load), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'd0);
      check("rst_rdata",   32'(bus_if.bus_rdata), 32'd0);
      rst = 1'b1;
      run_check("dflt", 163 * 32 + 2, 163, 162);

      // Read mux table
      for (int k = 0; k < 8; k++) begin
         rx_buffer = tbl[k].rxb;
         rda       = tbl[k].rda;
         tbr       = tbl[k].tbr;
         drive(tbl[k].cs, tbl[k].rw, tbl[k].addr, 8'h00);
         #1;
         check($sformatf("rdmux_%0d", k), 32'(bus_if.bus_rdata), 32'(tbl[k].exp));
         tick();
      end
      drive(1'b0, 1'b0, 2'd0, 8'h00);
      rda = 1'b0;
      tbr = 1'b1;
      tick();
      tick();

      // Reprogram divisor to 15
      drive(1'b1, 1'b0, 2'd2, 8'h0F);
      tick();
      drive(1'b1, 1'b0, 2'd3, 8'h00);
      tick();
      drive(1'b1, 1'b1, 2'd2, 8'h00);
      #1 check("div15_rd_lo", 32'(bus_if.bus_rdata), 32'h0F);
      drive(1'b1, 1'b1, 2'd3, 8'h00);
      #1 check("div15_rd_hi", 32'(bus_if.bus_rdata), 32'h00);
      drive(1'b0, 1'b0, 2'd0, 8'h00);
      run_check("div15", 16 * 17, 16, 15);

      // Staging the low byte must not change the active divisor
      drive(1'b1, 1'b0, 2'd2, 8'h07);
      tick();
      drive(1'b1, 1'b1, 2'd2, 8'h00);
      #1 check("stage_only_lo", 32'(bus_if.bus_rdata), 32'h0F);
      drive(1'b0, 1'b0, 2'd0, 8'h00);

      // Commit landing on the terminal-count cycle
      w = 0;
      while (rx_en !== 1'b1 && w < 40) begin
         tick();
         w++;
      end
      check("tc_rx_en_seen", 32'(rx_en), 32'd1);
      drive(1'b1, 1'b0, 2'd3, 8'h00);
      #1 check("tc_rx_en_same_cycle", 32'(rx_en), 32'd1);
      tick();
      drive(1'b0, 1'b0, 2'd0, 8'h00);
      run_check("tc", 8 * 17, 8, 7);

      // Held data read
      rda       = 1'b1;
      rx_buffer = 8'hA5;
      bad       = 0;
      acks      = 0;
      ackpos    = -1;
      drive(1'b1, 1'b1, 2'd0, 8'h00);
      for (int i = 0; i < 20; i++) begin
         #1;
         if (bus_if.bus_rdata !== 8'hA5) bad++;
         tick();
         if (rx_ack === 1'b1) begin
            acks++;
            if (ackpos < 0) ackpos = i + 1;
         end
      end
      drive(1'b0, 1'b0, 2'd0, 8'h00);
      check("hold_rdata_errs", 32'(bad), 32'd0);
      check("hold_ack_count",  32'(acks), 32'd1);
      check("hold_ack_pos",    32'(ackpos), 32'd1);
      tick();
      check("hold_ack_after", 32'(rx_ack), 32'd0);

      // Transmit write and overrun
      tbr = 1'b1;
      drive(1'b1, 1'b0, 2'd0, 8'h3C);
      tick();
      check("txw_load", 32'(tx_load), 32'd1);
      check("txw_data", 32'(tx_data), 32'h3C);
      drive(1'b0, 1'b0, 2'd0, 8'h00);
      tick();
      check("txw_load_width", 32'(tx_load), 32'd0);
      tbr = 1'b0;
      drive(1'b1, 1'b0, 2'd0, 8'h77);
      tick();
      check("ovr_no_load", 32'(tx_load), 32'd0);
      check("ovr_data_kept", 32'(tx_data), 32'h3C);
      drive(1'b0, 1'b0, 2'd0, 8'h00);
      tick();
      tbr = 1'b1;
      rda = 1'b1;
      drive(1'b1, 1'b1, 2'd1, 8'h00);
      #1 check("ovr_status1", 32'(bus_if.bus_rdata), 32'h07);
      tick();
      drive(1'b0, 1'b0, 2'd0, 8'h00);
      tick();
      drive(1'b1, 1'b1, 2'd1, 8'h00);
      #1 check("ovr_status2", 32'(bus_if.bus_rdata), 32'h03);
      drive(1'b0, 1'b0, 2'd0, 8'h00);
      tick();

      // Asynchronous reset with phase 9 and a write held
      drive(1'b1, 1'b0, 2'd2, 8'h03);
      tick();
      drive(1'b1, 1'b0, 2'd3, 8'h00);
      tick();
      drive(1'b0, 1'b0, 2'd0, 8'h00);
      repeat (36) tick();
      drive(1'b1, 1'b0, 2'd0, 8'h5A);
      tick();
      check("ar_pre_load", 32'(tx_load), 32'd1);
      #2 rst = 1'b0;
      #1;
      check("ar_load_clr", 32'(tx_load), 32'd0);
      check("ar_data_clr", 32'(tx_data), 32'd0);
      check("ar_rx_en",    32'(rx_en),   32'd0);
      check("ar_tx_en",    32'(tx_en),   32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      tick();
      check("ar_post_load", 32'(tx_load), 32'd1);
      check("ar_post_data", 32'(tx_data), 32'h5A);
      tick();
      check("ar_post_width", 32'(tx_load), 32'd0);
      drive(1'b1, 1'b1, 2'd2, 8'h00);
      #1 check("ar_div_lo", 32'(bus_if.bus_rdata), 32'hA2);
      drive(1'b1, 1'b1, 2'd3, 8'h00);
      #1 check("ar_div_hi", 32'(bus_if.bus_rdata), 32'h00);
      drive(1'b0, 1'b0, 2'd0, 8'h00);
      run_check("ar", 170, 163, 160);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/spart_baud_ctrl.md
# spart_baud_ctrl

Bus-side controller for the SPART. Decodes processor accesses (`iocs`/`iorw`/`ioaddr`), holds the programmable baud divisor, and generates the 16x-oversample enable (`rx_en`) for `uart_rx` and the 1x bit enable (`tx_en`) for the transmitter. It also sequences the receive and transmit handshakes: it issues `rx_ack` on a data read, issues `tx_load` on a data write, and reports status. It sits between the processor bus and the `uart_rx`/`uart_tx` datapaths.

## Interface
- `DEFAULT_DIV`, 16'd162: active divisor after reset. The `rx_en` period is `DEFAULT_DIV`+1 clocks.

- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `iocs` in 1: chip select.
- `iorw` in 1: 1 = read, 0 = write.
- `ioaddr` in 2: 00 data, 01 status, 10 divisor low, 11 divisor high.
- `bus_wdata` in 8: write data.
- `bus_rdata` out 8: read data (combinational).
- `rx_buffer` in 8: received byte from `uart_rx`.
- `rda` in 1: receive data available, from `uart_rx`.
- `tbr` in 1: transmit buffer ready, from `uart_tx`.
- `rx_en` out 1: one-cycle tick at 16x baud.
- `tx_en` out 1: one-cycle tick at 1x baud.
- `rx_ack` out 1: one-cycle pulse; the receiver clears `rda` on it.
- `tx_load` out 1: one-cycle pulse; the transmitter loads `tx_data` on it.
- `tx_data` out 8: byte to transmit, registered.

## Operation
- **Access detection**
  - Register `{iocs,iorw,ioaddr}` every cycle.
  - A *new access* is a cycle with `iocs`=1 where the previous cycle had `iocs`=0 or a different `{iorw,ioaddr}`.
  - Every side effect below (`rx_ack`, `tx_load`, register writes, sticky clear) fires once, on the new-access cycle only, however long `iocs` is held.
- **Read mux** (`iocs`=1, `iorw`=1):
  - 00 → `rx_buffer`
  - 01 → `{5'b0, ovr, tbr, rda}`
  - 10 → active divisor [7:0]
  - 11 → active divisor [15:8]
  - Otherwise `bus_rdata` = 8'h00.
- **Data read** (00): `rx_ack` pulses on the new-access cycle regardless of `rda`.
- **Status read** (01): `ovr` clears on the clock edge ending the new-access cycle, so the read still returns `ovr`=1.
- **Data write** (00):
  - If `tbr`=1: `tx_data` <= `bus_wdata` and `tx_load` pulses.
  - If `tbr`=0: write dropped, no `tx_load`, sticky `ovr` <= 1.
  - If an `ovr` set and a status-read clear land on the same edge, the set wins.
- **Divisor write**
  - Write to 10 updates the staging register `div_lo_s` only.
  - Write to 11 commits active divisor <= `{bus_wdata, div_lo_s}` atomically, then forces baud counter <= new divisor and phase <= 0 on the same edge.
  - Write to 01 is ignored.
- **Baud counter** (16-bit down counter)
  - When count == 0: `rx_en` = 1 and the counter reloads the active divisor.
  - Otherwise it decrements.
  - Divisor 0 gives `rx_en` every cycle.
- **Phase counter** (4-bit)
  - Increments on each `rx_en`, wrapping 15 → 0.
  - `tx_en` = `rx_en` & (phase == 15).
- **Commit coinciding with count == 0**
  - `rx_en` still asserts that cycle (it is decoded from the current count).
  - The commit's reload and phase clear take priority over the normal reload and increment.

## Timing
- **Reset (`rst`=0, async)**
  - Active divisor = `DEFAULT_DIV`, `div_lo_s` = 0, counter = `DEFAULT_DIV`, phase = 0, `ovr` = 0, `tx_data` = 0, access history cleared.
  - `rx_en`, `tx_en`, `rx_ack`, `tx_load` = 0.
  - `bus_rdata` is 0 unless a read is presented.
- **Reset asserted mid-access or mid-bit**: all state clears immediately. An access still held after release counts as a new access.
- **After reset release**: first `rx_en` at the `DEFAULT_DIV`+1-th rising edge; `rx_en` period thereafter is D+1 clocks; `tx_en` period is 16·(D+1).
- **Latency**
  - `rx_ack` and `tx_load` are registered: asserted the cycle after the new-access cycle, width exactly 1.
  - `tx_data` is valid in the same cycle as `tx_load`.
  - `bus_rdata`: zero latency, combinational from the current inputs and registers.
- **After a commit**: first `rx_en` arrives D'+1 clocks after the committing edge; first `tx_en` at the 16th `rx_en` after that.

## Test plan
- **Reset and default baud**
  - Stimulus: assert `rst`=0 then release, `DEFAULT_DIV`=162.
  - Required: every output 0 during reset; `rx_en` pulses at cycle 163 and every 163 cycles after; `tx_en` only on every 16th `rx_en` (period 2608).
- **Reprogram divisor**
  - Stimulus: write 10←0x0F, then 11←0x00.
  - Required: readback of 10 = 0x0F and 11 = 0x00; `rx_en` period becomes 16 starting 16 clocks after the commit edge; phase restarts, so the 16th subsequent `rx_en` carries `tx_en`.
- **Held data read**
  - Stimulus: `rda`=1, `rx_buffer`=0xA5, read 00 held 20 cycles.
  - Required: `bus_rdata`=0xA5 throughout; exactly one `rx_ack` pulse, one cycle after the access starts.
- **Transmit write and overrun**
  - Stimulus: `tbr`=1, write 00←0x3C; then `tbr`=0, write 00←0x77.
  - Required: first write gives `tx_load`=1 with `tx_data`=0x3C; second gives no `tx_load`, `tx_data` stays 0x3C.
  - Then: a status read returns 0x04 | {`tbr`,`rda`}; a second status read shows `ovr`=0.
- **Commit at terminal count**
  - Stimulus: time the write of 11 to land on the cycle where count == 0.
  - Required: `rx_en` asserted that cycle; the next `rx_en` follows the new divisor.
- **Asynchronous reset mid-operation**
  - Stimulus: assert `rst` with phase = 9 and a write held on `iocs`.
  - Required: outputs clear without waiting for a clock edge; after release the held write produces one `tx_load`; the divisor is back to 162.
